// File: rtl/acl2_motion_monitor.sv
// acl2_motion_monitor
// Sample sequencer and motion detector sitting between the alarm-system top
// level and the PmodACL2 accelerometer driver. Requests a sample every PERIOD
// cycles, compares each sample with the previous one per axis, and raises a
// sticky motion alarm after HITS consecutive over-threshold samples. A driver
// that never answers a request is reported through the sticky fault flag.
module acl2_motion_monitor #(
  parameter int PERIOD    = 1000000,
  parameter int THRESHOLD = 16,
  parameter int HITS      = 3,
  parameter int TIMEOUT   = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        alarmClear,
  input  logic        ready,
  output logic        fetch,
  input  logic        arrived,
  input  logic [31:0] acc,
  output logic [23:0] sample,
  output logic        sampleValid,
  output logic        motion,
  output logic        fault,
  output logic [7:0]  skipped
);

  localparam int TickW = $clog2(PERIOD);
  localparam int TimeW = $clog2(TIMEOUT + 1);

  localparam logic [TickW-1:0] tickLast  = TickW'(PERIOD - 1);
  localparam logic [TimeW-1:0] timeLimit = TimeW'(TIMEOUT);
  localparam logic [3:0]       hitMax    = 4'(HITS);
  localparam logic [8:0]       tripLevel = 9'(THRESHOLD);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TICK,
    WAIT_DATA,
    EVAL
  } stateT;

  stateT            state;
  logic [TickW-1:0] tickCount;
  logic [TimeW-1:0] waitCount;
  logic [23:0]      prevSample;
  logic             havePrev;
  logic [3:0]       hitCount;

  logic             tick;
  logic             issueFetch;
  logic             skipTick;
  logic             takeData;
  logic             dataTimeout;
  logic             evalStep;
  logic             tripped;
  logic [3:0]       hitNext;
  logic             motionSet;
  logic [8:0]       deltaX;
  logic [8:0]       deltaY;
  logic [8:0]       deltaZ;

  // The top byte of the driver word carries nothing this block needs.
  logic unusedAccHigh;
  assign unusedAccHigh = ^acc[31:24];

  // Absolute difference of two signed bytes. The 9-bit sign-extended
  // difference spans -255..255, so the magnitude always fits in 9 bits.
  function automatic logic [8:0] absDelta(input logic [7:0] newValue,
                                          input logic [7:0] oldValue);
    logic [8:0] diff;
    diff = {newValue[7], newValue} - {oldValue[7], oldValue};
    absDelta = diff[8] ? (~diff + 9'd1) : diff;
  endfunction

  // Sample-period counter; parked at zero whenever sampling is disabled so
  // that a fresh enable always waits a full period before the first request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tickCount <= '0;
    end else if (!enable) begin
      tickCount <= '0;
    end else if (tickCount == tickLast) begin
      tickCount <= '0;
    end else begin
      tickCount <= tickCount + TickW'(1);
    end
  end

  assign tick = enable && (tickCount == tickLast);

  // Per-axis motion evaluation of the latched sample against the previous one.
  always_comb begin
    deltaX  = absDelta(sample[23:16], prevSample[23:16]);
    deltaY  = absDelta(sample[15:8],  prevSample[15:8]);
    deltaZ  = absDelta(sample[7:0],   prevSample[7:0]);
    tripped = (deltaX >= tripLevel) || (deltaY >= tripLevel) ||
              (deltaZ >= tripLevel);
    hitNext = 4'd0;
    if (tripped) begin
      hitNext = (hitCount >= hitMax) ? hitMax : (hitCount + 4'd1);
    end
  end

  // Decode the per-cycle actions of the sequencer; a low enable overrides
  // every state so nothing below fires while the block is being shut down.
  always_comb begin
    issueFetch  = enable && (state == WAIT_TICK) && tick && ready;
    skipTick    = enable && tick &&
                  (((state == WAIT_TICK) && !ready) || (state == WAIT_DATA));
    takeData    = enable && (state == WAIT_DATA) && arrived;
    dataTimeout = enable && (state == WAIT_DATA) && !arrived &&
                  (waitCount == timeLimit);
    evalStep    = enable && (state == EVAL);
    motionSet   = evalStep && havePrev && (hitNext == hitMax);
  end

  // Sequencer state: wait for a period tick, wait for the driver, evaluate.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (!enable) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          state <= WAIT_TICK;
        end
        WAIT_TICK: begin
          if (issueFetch) begin
            state <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (takeData) begin
            state <= EVAL;
          end else if (dataTimeout) begin
            state <= WAIT_TICK;
          end
        end
        EVAL: begin
          state <= WAIT_TICK;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // One-cycle registered request pulse to the driver.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch <= 1'b0;
    end else begin
      fetch <= issueFetch;
    end
  end

  // Cycles spent waiting for the driver since the request was issued.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      waitCount <= '0;
    end else if (issueFetch) begin
      waitCount <= '0;
    end else if ((state == WAIT_DATA) && (waitCount != timeLimit)) begin
      waitCount <= waitCount + TimeW'(1);
    end
  end

  // Saturating count of period ticks that could not start a request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      skipped <= 8'd0;
    end else if (skipTick && (skipped != 8'hFF)) begin
      skipped <= skipped + 8'd1;
    end
  end

  // Latch the driver's sample and remember it as the next comparison base.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sample     <= 24'd0;
      prevSample <= 24'd0;
    end else begin
      if (takeData) begin
        sample <= acc[23:0];
      end
      if (evalStep) begin
        prevSample <= sample;
      end
    end
  end

  // Baseline flag: the first sample after a restart or a lost response
  // only establishes the reference and is never compared.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      havePrev <= 1'b0;
    end else if (!enable || dataTimeout) begin
      havePrev <= 1'b0;
    end else if (evalStep) begin
      havePrev <= 1'b1;
    end
  end

  // Consecutive tripped-sample counter; an evaluation in the same cycle as
  // a clear request keeps its own result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hitCount <= 4'd0;
    end else if (!enable || dataTimeout) begin
      hitCount <= 4'd0;
    end else if (evalStep && havePrev) begin
      hitCount <= hitNext;
    end else if (alarmClear) begin
      hitCount <= 4'd0;
    end
  end

  // Sticky alarm and fault flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      motion <= 1'b0;
      fault  <= 1'b0;
    end else begin
      if (motionSet) begin
        motion <= 1'b1;
      end else if (alarmClear) begin
        motion <= 1'b0;
      end
      if (dataTimeout) begin
        fault <= 1'b1;
      end else if (alarmClear) begin
        fault <= 1'b0;
      end
    end
  end

  // One pulse per evaluated sample, baseline samples included.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sampleValid <= 1'b0;
    end else begin
      sampleValid <= evalStep;
    end
  end

endmodule

// File: tb/tb_acl2_motion_monitor.sv
// tb_acl2_motion_monitor
// Directed bench for the motion monitor. A reference model built from
// cycle stamps and a run-length of tripped samples predicts every output,
// and a compare process checks the DUT against it on every cycle. Literal
// expectations at key points pin the model itself.
module tb_acl2_motion_monitor;

  localparam int PERIOD    = 100;
  localparam int THRESHOLD = 16;
  localparam int HITS      = 3;
  localparam int TIMEOUT   = 50;

  logic        clock      = 1'b0;
  logic        reset      = 1'b0;
  logic        enable     = 1'b0;
  logic        alarmClear = 1'b0;
  logic        ready      = 1'b0;
  logic        arrived    = 1'b0;
  logic [31:0] acc        = 32'd0;
  logic        fetch;
  logic [23:0] sample;
  logic        sampleValid;
  logic        motion;
  logic        fault;
  logic [7:0]  skipped;

  int     checks    = 0;
  int     failures  = 0;
  bit     compareOn = 1'b0;
  longint lastFetchTime = 0;

  acl2_motion_monitor #(
    .PERIOD   (PERIOD),
    .THRESHOLD(THRESHOLD),
    .HITS     (HITS),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .alarmClear (alarmClear),
    .ready      (ready),
    .fetch      (fetch),
    .arrived    (arrived),
    .acc        (acc),
    .sample     (sample),
    .sampleValid(sampleValid),
    .motion     (motion),
    .fault      (fault),
    .skipped    (skipped)
  );

  // 100 MHz-style free-running clock
  always #5 clock = ~clock;

  // Reference model state
  int          edgeNo    = 0;
  int          enRun     = 0;
  int          fetchEdge = 0;
  int          trips     = 0;
  bit          started   = 1'b0;
  bit          waiting   = 1'b0;
  bit          evalDue   = 1'b0;
  bit          mHavePrev = 1'b0;
  bit          tickNow   = 1'b0;
  bit          setMotion = 1'b0;
  bit          setFault  = 1'b0;
  logic [23:0] mPrev     = 24'd0;
  logic [23:0] mSample   = 24'd0;
  logic        mFetch    = 1'b0;
  logic        mValid    = 1'b0;
  logic        mMotion   = 1'b0;
  logic        mFault    = 1'b0;
  logic [7:0]  mSkipped  = 8'd0;

  // True when any axis moved by at least THRESHOLD between two samples
  function automatic bit sampleTrips(input logic [23:0] nowS, input logic [23:0] prevS);
    int d;
    sampleTrips = 1'b0;
    for (int a = 0; a < 3; a++) begin
      d = int'($signed(nowS[a*8 +: 8])) - int'($signed(prevS[a*8 +: 8]));
      if (d < 0) d = -d;
      if (d >= THRESHOLD) sampleTrips = 1'b1;
    end
  endfunction

  // Reference model: predicts the outputs visible after each clock edge
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      enRun = 0; fetchEdge = 0; trips = 0;
      started = 0; waiting = 0; evalDue = 0; mHavePrev = 0;
      mPrev = 0; mSample = 0; mFetch = 0; mValid = 0;
      mMotion = 0; mFault = 0; mSkipped = 0;
    end else begin
      edgeNo++;
      mFetch = 0; mValid = 0; setMotion = 0; setFault = 0;
      tickNow = enable && ((enRun % PERIOD) == PERIOD - 1);
      if (alarmClear) trips = 0;
      if (!enable) begin
        started = 0; waiting = 0; evalDue = 0; mHavePrev = 0; trips = 0; enRun = 0;
      end else begin
        enRun++;
        if (evalDue) begin
          evalDue = 0;
          mValid  = 1;
          if (!mHavePrev) begin
            mHavePrev = 1;
          end else begin
            if (sampleTrips(mSample, mPrev)) trips++;
            else trips = 0;
            if (trips >= HITS) setMotion = 1;
          end
          mPrev = mSample;
        end else if (waiting) begin
          if (tickNow && mSkipped != 8'hFF) mSkipped++;
          if (arrived) begin
            mSample = acc[23:0]; waiting = 0; evalDue = 1;
          end else if (edgeNo - fetchEdge == TIMEOUT + 1) begin
            setFault = 1; waiting = 0; mHavePrev = 0; trips = 0;
          end
        end else if (started) begin
          if (tickNow) begin
            if (ready) begin
              mFetch = 1; waiting = 1; fetchEdge = edgeNo;
            end else if (mSkipped != 8'hFF) begin
              mSkipped++;
            end
          end
        end else begin
          started = 1;
        end
      end
      if (alarmClear) begin mMotion = 0; mFault = 0; end
      if (setMotion) mMotion = 1;
      if (setFault) mFault = 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Cycle-by-cycle comparison of the DUT against the reference model
  initial begin
    forever begin
      @(negedge clock);
      if (compareOn) begin
        checkOutput("model.fetch",       32'(fetch),       32'(mFetch));
        checkOutput("model.sample",      32'(sample),      32'(mSample));
        checkOutput("model.sampleValid", 32'(sampleValid), 32'(mValid));
        checkOutput("model.motion",      32'(motion),      32'(mMotion));
        checkOutput("model.fault",       32'(fault),       32'(mFault));
        checkOutput("model.skipped",     32'(skipped),     32'(mSkipped));
      end
    end
  end

  task automatic tickClk();
    @(posedge clock);
    #1;
  endtask

  task automatic waitFetch(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 3 * PERIOD && !seen; i++) begin
      tickClk();
      if (fetch) seen = 1'b1;
    end
    lastFetchTime = $time;
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL fetchWait: got no fetch in %0d cycles, expected one", 3 * PERIOD);
    end
  endtask

  // Answer the next fetch 10 cycles later and follow the sample through EVAL
  task automatic applyStimulus(input logic [31:0] value);
    bit seen;
    waitFetch(seen);
    repeat (10) tickClk();
    acc     = value;
    arrived = 1'b1;
    tickClk();
    arrived = 1'b0;
    acc     = 32'hDEADBEEF;
    checkOutput("sampleLatch", 32'(sample), 32'(value[23:0]));
    checkOutput("sampleValidEarly", 32'(sampleValid), 32'd0);
    tickClk();
    checkOutput("sampleValidPulse", 32'(sampleValid), 32'd1);
  endtask

  task automatic restartSampling();
    enable = 1'b0;
    repeat (3) tickClk();
    enable = 1'b1;
  endtask

  task automatic pulseClear();
    alarmClear = 1'b1;
    tickClk();
    alarmClear = 1'b0;
  endtask

  // Abort the run if something hangs far beyond the expected length
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenario sequence
  initial begin
    bit     seen;
    int     count;
    longint firstFetch;

    #1 reset = 1'b1;
    compareOn = 1'b1;
    repeat (3) tickClk();
    checkOutput("resetFetch",   32'(fetch),       32'd0);
    checkOutput("resetSample",  32'(sample),      32'd0);
    checkOutput("resetValid",   32'(sampleValid), 32'd0);
    checkOutput("resetMotion",  32'(motion),      32'd0);
    checkOutput("resetFault",   32'(fault),       32'd0);
    checkOutput("resetSkipped", 32'(skipped),     32'd0);
    reset  = 1'b0;
    enable = 1'b1;
    ready  = 1'b1;

    // Basic cycle: two identical samples, top byte ignored
    applyStimulus(32'h00102030);
    firstFetch = lastFetchTime;
    applyStimulus(32'hFF102030);
    checkOutput("basicSample", 32'(sample), 32'h102030);
    checkOutput("fetchGap", 32'((lastFetchTime - firstFetch) / 10), 32'd100);
    checkOutput("basicMotion", 32'(motion), 32'd0);

    // Trip on X: third tripped delta raises motion
    restartSampling();
    applyStimulus(32'h00000000);
    applyStimulus(32'h00140000);
    applyStimulus(32'h00280000);
    checkOutput("tripBefore", 32'(motion), 32'd0);
    applyStimulus(32'h003C0000);
    checkOutput("tripRaised", 32'(motion), 32'd1);
    applyStimulus(32'h00500000);
    checkOutput("tripSticky", 32'(motion), 32'd1);
    pulseClear();
    checkOutput("tripCleared", 32'(motion), 32'd0);

    // Deltas of 15 never trip
    applyStimulus(32'h005F0000);
    applyStimulus(32'h006E0000);
    applyStimulus(32'h007D0000);
    checkOutput("delta15", 32'(motion), 32'd0);

    // Y wraps from +127 to -128: |d| = 255
    restartSampling();
    applyStimulus(32'h00003F00);
    applyStimulus(32'h00005F00);
    applyStimulus(32'h00007F00);
    checkOutput("wrapBefore", 32'(motion), 32'd0);
    applyStimulus(32'h00008000);
    checkOutput("wrapTrip", 32'(motion), 32'd1);
    pulseClear();

    // Z crosses zero: -8 to +8 is exactly the threshold
    restartSampling();
    applyStimulus(32'h000000D8);
    applyStimulus(32'h000000E8);
    applyStimulus(32'h000000F8);
    checkOutput("signBefore", 32'(motion), 32'd0);
    applyStimulus(32'h00000008);
    checkOutput("signTrip16", 32'(motion), 32'd1);
    pulseClear();

    // -8 to +7 is one short of the threshold
    restartSampling();
    applyStimulus(32'h000000D8);
    applyStimulus(32'h000000E8);
    applyStimulus(32'h000000F8);
    applyStimulus(32'h00000007);
    checkOutput("signQuiet15", 32'(motion), 32'd0);

    // Tripped, tripped, quiet, tripped, tripped never reaches HITS
    restartSampling();
    applyStimulus(32'h00000000);
    applyStimulus(32'h00140000);
    applyStimulus(32'h00280000);
    applyStimulus(32'h00280000);
    applyStimulus(32'h003C0000);
    applyStimulus(32'h00500000);
    checkOutput("hitReset", 32'(motion), 32'd0);

    // Driver never answers: fault exactly TIMEOUT+1 cycles after fetch
    waitFetch(seen);
    repeat (TIMEOUT) tickClk();
    checkOutput("faultEarly", 32'(fault), 32'd0);
    tickClk();
    checkOutput("faultRaised", 32'(fault), 32'd1);

    // Driver busy across three ticks
    ready = 1'b0;
    count = 0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      tickClk();
      if (fetch) count++;
    end
    checkOutput("busyNoFetch", 32'(count), 32'd0);
    checkOutput("busySkipped", 32'(skipped), 32'd3);
    ready = 1'b1;
    pulseClear();
    checkOutput("faultCleared", 32'(fault), 32'd0);
    checkOutput("skippedHeld", 32'(skipped), 32'd3);

    // Abort mid-request: the late answer is dropped and the baseline reset
    applyStimulus(32'h00500000);
    waitFetch(seen);
    repeat (5) tickClk();
    enable = 1'b0;
    repeat (3) tickClk();
    acc     = 32'h00112233;
    arrived = 1'b1;
    tickClk();
    arrived = 1'b0;
    count   = 0;
    for (int i = 0; i < 6; i++) begin
      tickClk();
      if (sampleValid) count++;
    end
    checkOutput("abortNoValid", 32'(count), 32'd0);
    checkOutput("abortSampleHeld", 32'(sample), 32'h500000);
    enable = 1'b1;
    applyStimulus(32'h00000000);
    applyStimulus(32'h00140000);
    applyStimulus(32'h00280000);
    checkOutput("abortBaseline", 32'(motion), 32'd0);
    applyStimulus(32'h003C0000);
    checkOutput("abortTrip", 32'(motion), 32'd1);

    // Reset in the middle of a request; the late answer lands in IDLE
    waitFetch(seen);
    repeat (5) tickClk();
    reset = 1'b1;
    tickClk();
    checkOutput("midResetFetch",   32'(fetch),       32'd0);
    checkOutput("midResetSample",  32'(sample),      32'd0);
    checkOutput("midResetValid",   32'(sampleValid), 32'd0);
    checkOutput("midResetMotion",  32'(motion),      32'd0);
    checkOutput("midResetFault",   32'(fault),       32'd0);
    checkOutput("midResetSkipped", 32'(skipped),     32'd0);
    tickClk();
    reset   = 1'b0;
    acc     = 32'h00777777;
    arrived = 1'b1;
    tickClk();
    arrived = 1'b0;
    count   = 0;
    for (int i = 0; i < 6; i++) begin
      tickClk();
      if (sampleValid) count++;
    end
    checkOutput("lateArrivedValid", 32'(count), 32'd0);
    checkOutput("lateArrivedSample", 32'(sample), 32'd0);

    compareOn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
